mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Memory-side responder for the 5-stage CPU. Serves instruction-fetch (I) and load/store (D) requests
//   from the IF and MEM slices through one shared single-port memory bus with variable latency.
// - Drives the pipeline stall and implements halt drain. Flags a bus timeout.
// PARAMETERS
// - ADDR_W       16   address width (word addressed)
// - DATA_W       16   data width
// - TIMEOUT_CYC  64   max cycles from mem_req to mem_ack before error; >=2
// PORTS
// - clk        in   1       clock, all state on rising edge
// - rst        in   1       reset, asynchronous, active-low (0 = reset)
// - hlt        in   1       halt request from CPU
// - i_req      in   1       fetch request, held until i_done
// - i_addr     in   ADDR_W  fetch address
// - i_rdata    out  DATA_W  fetched instruction, valid when i_done=1
// - i_done     out  1       one-cycle completion pulse, I side
// - d_req      in   1       load/store request, held until d_done
// - d_we       in   1       1 = store
// - d_addr     in   ADDR_W  data address
// - d_wdata    in   DATA_W  store data
// - d_rdata    out  DATA_W  load data, valid when d_done=1
// - d_done     out  1       one-cycle completion pulse, D side
// - stall      out  1       pipeline stall to IF/ID/EX/MEM/WB
// - halted     out  1       drain complete, sticky until reset
// - err        out  1       bus timeout, sticky until reset
// - mem_req    out  1       bus request, held until mem_ack
// - mem_we     out  1       bus write enable
// - mem_addr   out  ADDR_W  bus address
// - mem_wdata  out  DATA_W  bus write data
// - mem_rdata  in   DATA_W  bus read data, valid with mem_ack
// - mem_ack    in   1       bus completion, single-cycle
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE. mem_req/mem_we/i_done/d_done/halted/err=0.
//   mem_addr/mem_wdata/i_rdata/d_rdata=0. hlt latch and watchdog cleared. Takes effect mid-transaction.
// - FSM states: IDLE, D_ACC, I_ACC, DONE, HALTED, ERR.
// - IDLE:
//   - d_req -> D_ACC (D has priority; I waits).
//   - else i_req && !hlt_q -> I_ACC.
//   - else hlt_q -> HALTED.
//   - On grant, register addr/we/wdata to the mem_* outputs. Captured values stay stable during ACC.
// - D_ACC/I_ACC: mem_req=1 every cycle.
//   - On mem_ack: capture mem_rdata into the side's rdata register. D stores leave d_rdata unchanged.
//   - Then go to DONE.
// - DONE: the matching done pulses for exactly one cycle. mem_req=0. No grant in this cycle.
//   Next state is IDLE. The requester drops or changes req by the following cycle.
// - Latency: req in IDLE at cycle 0; mem_req at 1; mem_ack at k>=1; done at k+1; next grant at k+2 earliest.
// - rdata registers hold their value until the next completion on that side.
// - stall = (i_req & ~i_done) | (d_req & ~d_done) | (state==ERR). Combinational.
// - hlt: latched into hlt_q (sticky). Blocks new I grants only.
//   An in-flight I access completes normally. D requests are still served until none remain.
// - HALTED: halted=1. Ignores all requests. Exit only by reset.
// - Watchdog: counts cycles in ACC and clears on grant.
//   If count reaches TIMEOUT_CYC without mem_ack -> ERR: mem_req=0, err=1, stall=1. Exit only by reset.
// - mem_ack outside ACC is ignored.
// - Simultaneous i_req & d_req: D is served first, then I, in strict order.
// STRUCTURE
// - Package cpu_mem_pkg: ADDR_W/DATA_W constants and the arb_state_t enum.
// - Sub-module mem_watchdog: counter with clear, enable and expire output, parameterised by TIMEOUT_CYC.
// - Everything else is inline.
// TESTING
// - Fetch, mem_ack 2 cycles after mem_req, mem_rdata=16'hA5C3
//   -> i_done 1 cycle after ack, i_rdata=A5C3, stall low in the done cycle.
// - i_req & d_req both in cycle 0, store 16'h1234 to 16'h0040
//   -> bus write first, then fetch; d_done precedes i_done; stall held until i_done.
// - hlt while a fetch is in flight with a pending load
//   -> fetch completes, load completes, then halted=1; a new i_req gets no mem_req.
// - mem_ack withheld for TIMEOUT_CYC=64 cycles -> err=1 at cycle 64, mem_req=0, stall=1 held.
// - rst=0 asynchronously mid D_ACC -> mem_req=0 immediately; after release, IDLE and a fresh fetch works.
// - Spurious mem_ack in IDLE -> no done pulse, rdata unchanged.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared widths and the arbiter state encoding for the CPU memory port.
package cpu_mem_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_ACC  = 3'd1,
      I_ACC  = 3'd2,
      DONE   = 3'd3,
      HALTED = 3'd4,
      ERR    = 3'd5
   } arb_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Bus watchdog: counts cycles of an outstanding access and flags when the
// access is about to exceed TIMEOUT_CYC cycles measured from the grant cycle.
module mem_watchdog #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] count;

   // The grant cycle counts as cycle 1, so the first bus cycle sees 1 and the
   // limit is hit on the last bus cycle before TIMEOUT_CYC is reached.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= CNT_W'(1);
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory-side responder: shares one single-port bus between instruction fetch
// and load/store, drives the pipeline stall, drains on halt, flags bus timeout.
module mem_port_arbiter #(
   parameter int ADDR_W      = cpu_mem_pkg::ADDR_W,
   parameter int DATA_W      = cpu_mem_pkg::DATA_W,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hlt,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              stall,
   output logic              halted,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   import cpu_mem_pkg::*;

   arb_state_t        state;
   arb_state_t        state_next;
   logic              grant_d;
   logic              grant_i;
   logic              in_acc;
   logic              wd_expired;
   logic              side_d;
   logic              hlt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   assign in_acc = (state == D_ACC) || (state == I_ACC);

   mem_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (grant_d | grant_i),
      .enable (in_acc),
      .expired(wd_expired)
   );

   // Next-state and grant decode: D wins over I, halt only blocks new fetches.
   always_comb begin
      state_next = state;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      case (state)
         IDLE: begin
            if (d_req) begin
               grant_d    = 1'b1;
               state_next = D_ACC;
            end else if (i_req && !hlt_q) begin
               grant_i    = 1'b1;
               state_next = I_ACC;
            end else if (hlt_q) begin
               state_next = HALTED;
            end
         end
         D_ACC, I_ACC: begin
            if (mem_ack) begin
               state_next = DONE;
            end else if (wd_expired) begin
               state_next = ERR;
            end
         end
         DONE:    state_next = IDLE;
         HALTED:  state_next = HALTED;
         ERR:     state_next = ERR;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Capture the granted request so the bus sees stable values for the whole access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         side_d  <= 1'b0;
      end else if (grant_d) begin
         addr_q  <= d_addr;
         we_q    <= d_we;
         wdata_q <= d_wdata;
         side_d  <= 1'b1;
      end else if (grant_i) begin
         addr_q  <= i_addr;
         we_q    <= 1'b0;
         side_d  <= 1'b0;
      end
   end

   // Read data lands in the owning side's register; stores leave d_rdata alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (mem_ack) begin
         if (state == I_ACC) begin
            i_rdata_q <= mem_rdata;
         end else if ((state == D_ACC) && !we_q) begin
            d_rdata_q <= mem_rdata;
         end
      end
   end

   // Halt request is sticky until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hlt_q <= 1'b0;
      end else if (hlt) begin
         hlt_q <= 1'b1;
      end
   end

   assign mem_req   = in_acc;
   assign mem_we    = we_q & in_acc;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_done    = (state == DONE) && !side_d;
   assign d_done    = (state == DONE) && side_d;
   assign halted    = (state == HALTED);
   assign err       = (state == ERR);
   assign stall     = (i_req & ~i_done) | (d_req & ~d_done) | (state == ERR);

endmodule
